// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder sequencing nibbles through add_4
module add_4 (
    output logic [3:0] s,
    output logic       co,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [WIDTH-1:0] op_a, op_b;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [IW+1:0]   base;
    logic [3:0]      nib_s;
    logic            nib_co;

    // Bit offset of the current nibble; the carry between nibbles only passes through the carry register.
    assign base = {idx, 2'b00};

    add_4 u_add_4 (
        .s  (nib_s),
        .co (nib_co),
        .a  (op_a[base +: 4]),
        .b  (op_b[base +: 4]),
        .ci (carry)
    );

    assign in_ready = (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)     state_next = RUN;
            RUN:     if (idx == LAST)  state_next = DONE;
            DONE:    if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum[base +: 4] <= nib_s;
                    carry          <= nib_co;
                    idx            <= idx + 1'b1;
                    if (idx == LAST) cout <= nib_co;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder (WIDTH=16)
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;

    int checks = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic txn(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input int hold, output logic [15:0] rs, output logic rc, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rs = sum;
        rc = cout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [15:0] rs, hold_sum;
        logic        rc, hold_cout, seen_valid;
        logic [16:0] model;
        int          lat;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[5] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Leave a nonzero result behind, then reset asynchronously between edges.
        txn(16'hABCD, 16'h1111, 1'b1, 0, rs, rc, lat);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'h0000);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            txn(vecs[i].va, vecs[i].vb, vecs[i].vc, 0, rs, rc, lat);
            check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_idle_after", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result held while new operands are offered.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd4);
        hold_sum = sum;
        hold_cout = cout;
        check("bp_sum", 32'(hold_sum), 32'h5555);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'(k & 1); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            check("bp_sum_stable", 32'(sum), 32'(hold_sum));
            check("bp_cout_stable", 32'(cout), 32'(hold_cout));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_high", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp_no_accept", 32'(in_ready), 32'd1);

        // Reset after two RUN edges discards the transaction.
        a = 16'h00FF; b = 16'h0F0F; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        #3 rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_never_valid", 32'(seen_valid), 32'd0);
        check("midrst_idle", 32'(in_ready), 32'd1);
        txn(16'h0001, 16'h0001, 1'b0, 0, rs, rc, lat);
        check("midrst_next_sum", 32'(rs), 32'h0002);
        check("midrst_next_cout", 32'(rc), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rcin;
            ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
            model = 17'(ra) + 17'(rb) + 17'(rcin);
            txn(ra, rb, rcin, int'($urandom_range(0, 3)), rs, rc, lat);
            check($sformatf("rand%0d_sum", i), 32'(rs), 32'(model[15:0]));
            check($sformatf("rand%0d_cout", i), 32'(rc), 32'(model[16]));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that adds two WIDTH-bit operands four bits per cycle. It reuses the team's existing 4-bit ripple adder `add_4` (ports `s[3:0]`, `co`, `a[3:0]`, `b[3:0]`, `ci`) as its only arithmetic element. The block is the sequencing stage directly upstream of `add_4`: it slices the operands into nibbles, feeds them to `add_4`, and collects the nibble sums into a full-width result. Operands arrive on a valid/ready input; results leave on a valid/ready output.

## Interface
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. NIB = WIDTH/4.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands. Combinational: high exactly when state is IDLE.
- a  in  WIDTH  operand A, sampled on the input handshake.
- b  in  WIDTH  operand B, sampled on the input handshake.
- cin  in  1  carry-in, sampled on the input handshake.
- out_valid  out  1  result available; registered.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, registered; {cout,sum} = a + b + cin.
- cout  out  1  carry-out of the MSB nibble, registered.

## Operation
- **States:** IDLE, RUN, DONE. Reset state is IDLE.
- **Internal registers:**
  - op_a, op_b: WIDTH each.
  - carry: 1 bit.
  - idx: ceil(log2(NIB)) bits, minimum 1.
- **IDLE:**
  - in_ready=1, out_valid=0.
  - On in_valid=1: latch a→op_a, b→op_b, cin→carry; set idx=0 and sum=0; go to RUN.
- **RUN:**
  - in_ready=0, out_valid=0.
  - `add_4` inputs: op_a[4*idx+:4], op_b[4*idx+:4], ci=carry.
  - Each edge: write sum[4*idx+:4] from `add_4`.s, set carry from `add_4`.co, increment idx.
  - When idx==NIB-1, the same edge also writes cout from `add_4`.co and moves to DONE.
- **DONE:**
  - out_valid=1, in_ready=0.
  - sum and cout held stable.
  - On out_ready=1 go to IDLE. out_ready is ignored in all other states.
- **Input discipline:**
  - in_valid is ignored outside IDLE.
  - a, b and cin are don't-care except on the handshake edge.
- **Arithmetic:**
  - Modulo 2^WIDTH sum with carry-out.
  - Nibble carries chain only through the carry register; there is no combinational carry path between nibbles.
- **Reset:**
  - rst_n low forces, immediately and regardless of clk: state=IDLE, sum=0, cout=0, out_valid=0, op_a=0, op_b=0, carry=0, idx=0.
  - Reset mid-RUN or mid-DONE discards the transaction; no result is ever presented for it.
- **Simultaneous events:** none across the two handshakes, because in_ready and out_valid are never high together.

## Timing
- Accept edge E0 is the IDLE edge with in_valid=1.
- RUN occupies edges E1..E_NIB, one nibble per edge, LSB nibble first.
- out_valid rises after edge E_NIB. Latency from accept edge to out_valid is NIB cycles (4 for WIDTH=16, 1 for WIDTH=4).
- The output handshake edge returns the block to IDLE. in_ready is high in the following cycle.
- Minimum initiation interval is NIB+2 cycles.
- sum nibbles fill progressively during RUN. sum is valid only while out_valid=1.
- After the DONE→IDLE edge, sum and cout keep their values until the next accept clears sum.
- in_ready is 1 while rst_n is low. The reset value of state is IDLE, but handshakes while rst_n is low have no effect.

## Test plan
- **Reset:** assert rst_n=0 mid-clock.
  - Required immediately: out_valid=0, sum=0x0000, cout=0, in_ready=1.
- **Basic add (WIDTH=16):** a=0x1234, b=0x1111, cin=0.
  - Required: sum=0x2345, cout=0.
  - out_valid must rise exactly 4 cycles after the accept edge.
- **Full carry ripple:** a=0xFFFF, b=0x0000, cin=1.
  - Required: sum=0x0000, cout=1.
  - Also a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands.
  - Required: sum/cout stable, in_ready=0, no new accept.
  - Releasing out_ready gives IDLE next cycle.
- **Back-to-back:** 0x8000+0x8000, cin=0 → sum 0x0000, cout=1. Then, accepted in the first IDLE cycle, 0x7FFF+0x0001, cin=0.
  - Required second result: sum=0x8000, cout=0, so no stale carry.
- **Reset mid-operation:** pull rst_n low after two RUN edges, release, and wait 10 cycles.
  - Required: out_valid never asserts and the block sits in IDLE.
  - A subsequent 0x0001+0x0001 then yields sum=0x0002.
